// File: rtl/ps2_zx_matrix.sv
// ps2_zx_matrix: PS/2 set-2 scancode to ZX Spectrum 8x5 keyboard matrix decoder.
// Tracks E0/F0 prefixes, skips the 8-byte E1 (Pause) sequence, and folds cursor
// keys and backspace onto CAPS SHIFT plus a digit. Also keeps a function-key vector.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   kbd_key        - scancode byte, stable while kbd_key_valid is high
//   kbd_key_valid  - byte available (edge-detected unless VALID_LEVEL=1)
//   addr_hi        - CPU A[15:8], a 0 bit selects a half-row
//   row_data       - active-low D4..D0, AND of all selected half-rows
//   fkeys          - active-high function-key vector (NUM_FKEYS wide)
//   key_event      - one-cycle pulse per consumed make/break of a mapped key
module ps2_zx_matrix #(
  parameter int unsigned NUM_FKEYS   = 9,
  parameter int unsigned EXT_ENABLE  = 1,
  parameter int unsigned VALID_LEVEL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           kbd_key,
  input  logic                 kbd_key_valid,
  input  logic [7:0]           addr_hi,
  output logic [4:0]           row_data,
  output logic [NUM_FKEYS-1:0] fkeys,
  output logic                 key_event
);

  localparam int unsigned NROWS = 8;
  localparam int unsigned NCOLS = 5;

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXTBRK, SKIP} state_t;

  state_t                         state;
  logic [2:0]                     skip_cnt;
  logic                           valid_q;
  logic [NROWS-1:0][NCOLS-1:0]    mat;
  logic [3:0]                     cur;      // [0]left [1]down [2]up [3]right
  logic                           bksp;
  logic [NUM_FKEYS-1:0]           fk;

  logic                           accept;
  logic                           m_hit;
  logic [2:0]                     m_row;
  logic [2:0]                     m_col;
  logic                           f_hit;
  logic [3:0]                     f_idx;
  logic                           b_hit;
  logic                           e_hit;
  logic [1:0]                     e_idx;
  logic [NROWS-1:0][NCOLS-1:0]    m_mask;
  logic [NUM_FKEYS-1:0]           fk_mask;
  logic [3:0]                     e_mask;
  logic                           norm_mapped;
  logic                           ext_mapped;
  logic                           do_norm;
  logic                           do_ext;
  logic                           mk;
  logic                           is_prefix;
  logic [NROWS-1:0][NCOLS-1:0]    eff;
  logic [NCOLS-1:0]               acc;

  // Byte strobe: either a ready-made strobe or a rising edge of the valid level.
  assign accept = (VALID_LEVEL != 0) ? kbd_key_valid : (kbd_key_valid & ~valid_q);

  // Non-extended matrix position of the current byte.
  always_comb begin
    {m_hit, m_row, m_col} = 7'd0;
    case (kbd_key)
      8'h12: {m_hit, m_row, m_col} = {1'b1, 3'd0, 3'd0};
      8'h1A: {m_hit, m_row, m_col} = {1'b1, 3'd0, 3'd1};
      8'h22: {m_hit, m_row, m_col} = {1'b1, 3'd0, 3'd2};
      8'h21: {m_hit, m_row, m_col} = {1'b1, 3'd0, 3'd3};
      8'h2A: {m_hit, m_row, m_col} = {1'b1, 3'd0, 3'd4};
      8'h1C: {m_hit, m_row, m_col} = {1'b1, 3'd1, 3'd0};
      8'h1B: {m_hit, m_row, m_col} = {1'b1, 3'd1, 3'd1};
      8'h23: {m_hit, m_row, m_col} = {1'b1, 3'd1, 3'd2};
      8'h2B: {m_hit, m_row, m_col} = {1'b1, 3'd1, 3'd3};
      8'h34: {m_hit, m_row, m_col} = {1'b1, 3'd1, 3'd4};
      8'h15: {m_hit, m_row, m_col} = {1'b1, 3'd2, 3'd0};
      8'h1D: {m_hit, m_row, m_col} = {1'b1, 3'd2, 3'd1};
      8'h24: {m_hit, m_row, m_col} = {1'b1, 3'd2, 3'd2};
      8'h2D: {m_hit, m_row, m_col} = {1'b1, 3'd2, 3'd3};
      8'h2C: {m_hit, m_row, m_col} = {1'b1, 3'd2, 3'd4};
      8'h16: {m_hit, m_row, m_col} = {1'b1, 3'd3, 3'd0};
      8'h1E: {m_hit, m_row, m_col} = {1'b1, 3'd3, 3'd1};
      8'h26: {m_hit, m_row, m_col} = {1'b1, 3'd3, 3'd2};
      8'h25: {m_hit, m_row, m_col} = {1'b1, 3'd3, 3'd3};
      8'h2E: {m_hit, m_row, m_col} = {1'b1, 3'd3, 3'd4};
      8'h45: {m_hit, m_row, m_col} = {1'b1, 3'd4, 3'd0};
      8'h46: {m_hit, m_row, m_col} = {1'b1, 3'd4, 3'd1};
      8'h3E: {m_hit, m_row, m_col} = {1'b1, 3'd4, 3'd2};
      8'h3D: {m_hit, m_row, m_col} = {1'b1, 3'd4, 3'd3};
      8'h36: {m_hit, m_row, m_col} = {1'b1, 3'd4, 3'd4};
      8'h4D: {m_hit, m_row, m_col} = {1'b1, 3'd5, 3'd0};
      8'h44: {m_hit, m_row, m_col} = {1'b1, 3'd5, 3'd1};
      8'h43: {m_hit, m_row, m_col} = {1'b1, 3'd5, 3'd2};
      8'h3C: {m_hit, m_row, m_col} = {1'b1, 3'd5, 3'd3};
      8'h35: {m_hit, m_row, m_col} = {1'b1, 3'd5, 3'd4};
      8'h5A: {m_hit, m_row, m_col} = {1'b1, 3'd6, 3'd0};
      8'h4B: {m_hit, m_row, m_col} = {1'b1, 3'd6, 3'd1};
      8'h42: {m_hit, m_row, m_col} = {1'b1, 3'd6, 3'd2};
      8'h3B: {m_hit, m_row, m_col} = {1'b1, 3'd6, 3'd3};
      8'h33: {m_hit, m_row, m_col} = {1'b1, 3'd6, 3'd4};
      8'h29: {m_hit, m_row, m_col} = {1'b1, 3'd7, 3'd0};
      8'h14: {m_hit, m_row, m_col} = {1'b1, 3'd7, 3'd1};
      8'h3A: {m_hit, m_row, m_col} = {1'b1, 3'd7, 3'd2};
      8'h31: {m_hit, m_row, m_col} = {1'b1, 3'd7, 3'd3};
      8'h32: {m_hit, m_row, m_col} = {1'b1, 3'd7, 3'd4};
      default: ;
    endcase
  end

  // Function keys, backspace and extended cursor codes.
  always_comb begin
    {f_hit, f_idx} = 5'd0;
    case (kbd_key)
      8'h07: {f_hit, f_idx} = {1'b1, 4'd0};
      8'h0E: {f_hit, f_idx} = {1'b1, 4'd1};
      8'h78: {f_hit, f_idx} = {1'b1, 4'd2};
      8'h09: {f_hit, f_idx} = {1'b1, 4'd3};
      8'h01: {f_hit, f_idx} = {1'b1, 4'd4};
      8'h0A: {f_hit, f_idx} = {1'b1, 4'd5};
      8'h83: {f_hit, f_idx} = {1'b1, 4'd6};
      8'h0B: {f_hit, f_idx} = {1'b1, 4'd7};
      8'h03: {f_hit, f_idx} = {1'b1, 4'd8};
      default: ;
    endcase
    {e_hit, e_idx} = 3'd0;
    case (kbd_key)
      8'h6B: {e_hit, e_idx} = {1'b1, 2'd0};
      8'h72: {e_hit, e_idx} = {1'b1, 2'd1};
      8'h75: {e_hit, e_idx} = {1'b1, 2'd2};
      8'h74: {e_hit, e_idx} = {1'b1, 2'd3};
      default: ;
    endcase
    b_hit = (kbd_key == 8'h66);
  end

  // One-hot update masks and mapped/apply qualifiers.
  always_comb begin
    m_mask = '0;
    if (m_hit) m_mask[m_row][m_col] = 1'b1;
    fk_mask = '0;
    for (int i = 0; i < int'(NUM_FKEYS); i++) begin
      fk_mask[i] = f_hit && (f_idx == 4'(i));
    end
    e_mask = '0;
    if (e_hit && (EXT_ENABLE != 0)) e_mask[e_idx] = 1'b1;
    norm_mapped = m_hit | b_hit | (|fk_mask);
    ext_mapped  = |e_mask;
    is_prefix   = (kbd_key == 8'hF0) || (kbd_key == 8'hE0) || (kbd_key == 8'hE1);
    do_norm = accept && (((state == IDLE) && !is_prefix) || (state == BRK));
    do_ext  = accept && (((state == EXT) && (kbd_key != 8'hF0)) || (state == EXTBRK));
    mk      = (state == IDLE) || (state == EXT);
  end

  // Prefix FSM plus key-state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      skip_cnt  <= 3'd0;
      valid_q   <= 1'b0;
      mat       <= '0;
      cur       <= '0;
      bksp      <= 1'b0;
      fk        <= '0;
      key_event <= 1'b0;
    end else begin
      valid_q   <= kbd_key_valid;
      key_event <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (kbd_key == 8'hF0)      state <= BRK;
            else if (kbd_key == 8'hE0) state <= EXT;
            else if (kbd_key == 8'hE1) begin
              state    <= SKIP;
              skip_cnt <= 3'd7;
            end
          end
          BRK:    state <= IDLE;
          EXT:    state <= (kbd_key == 8'hF0) ? EXTBRK : IDLE;
          EXTBRK: state <= IDLE;
          SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (do_norm) begin
        mat       <= mk ? (mat | m_mask) : (mat & ~m_mask);
        fk        <= mk ? (fk | fk_mask) : (fk & ~fk_mask);
        if (b_hit) bksp <= mk;
        key_event <= norm_mapped;
      end
      if (do_ext) begin
        cur       <= mk ? (cur | e_mask) : (cur & ~e_mask);
        key_event <= ext_mapped;
      end
    end
  end

  // Composite keys add CAPS SHIFT and their digit on top of the physical matrix.
  always_comb begin
    eff       = mat;
    eff[0][0] = mat[0][0] | bksp | (|cur);
    eff[3][4] = mat[3][4] | cur[0];
    eff[4][4] = mat[4][4] | cur[1];
    eff[4][3] = mat[4][3] | cur[2];
    eff[4][2] = mat[4][2] | cur[3];
    eff[4][0] = mat[4][0] | bksp;
  end

  // ULA read: OR the pressed bits of every selected half-row, then invert.
  always_comb begin
    acc = '0;
    for (int r = 0; r < int'(NROWS); r++) begin
      if (!addr_hi[r]) acc = acc | eff[r];
    end
    row_data = ~acc;
  end

  assign fkeys = fk;

endmodule

// File: tb/tb_ps2_zx_matrix.sv
// tb_ps2_zx_matrix: scoreboard bench for ps2_zx_matrix. Expectations are queued
// alongside each stimulus block and drained against the DUT afterwards.
// A second instance with NUM_FKEYS=4 shares all inputs.
module tb_ps2_zx_matrix;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] kbd_key;
  logic       kbd_key_valid;
  logic [7:0] addr_hi;
  logic [4:0] row_data;
  logic [8:0] fkeys;
  logic       key_event;
  logic [4:0] row_data4;
  logic [3:0] fkeys4;
  logic       key_event4;

  int n_checks = 0;
  int n_errors = 0;
  int ev_cnt   = 0;
  int ev_base  = 0;

  typedef struct {
    string      tag;
    int         kind;   // 0 row_data@addr, 1 fkeys, 2 fkeys(4), 3 key_event count, 4 key_event level
    logic [7:0] addr;
    logic [8:0] exp;
  } exp_t;

  exp_t sbq[$];

  ps2_zx_matrix dut (
    .clk(clk), .reset(reset), .kbd_key(kbd_key), .kbd_key_valid(kbd_key_valid),
    .addr_hi(addr_hi), .row_data(row_data), .fkeys(fkeys), .key_event(key_event)
  );

  ps2_zx_matrix #(.NUM_FKEYS(4)) dut4 (
    .clk(clk), .reset(reset), .kbd_key(kbd_key), .kbd_key_valid(kbd_key_valid),
    .addr_hi(addr_hi), .row_data(row_data4), .fkeys(fkeys4), .key_event(key_event4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (key_event) ev_cnt <= ev_cnt + 1;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [7:0] a, input logic [8:0] e);
    exp_t x;
    x.tag = tag; x.kind = kind; x.addr = a; x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic push_row(input string tag, input logic [7:0] a, input logic [4:0] e);
    push(tag, 0, a, 9'(e));
  endtask

  task automatic push_ev(input string tag, input int n);
    push(tag, 3, 8'hFF, 9'(n));
  endtask

  task automatic drain();
    exp_t x;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      case (x.kind)
        0: begin addr_hi = x.addr; #1; check_eq(x.tag, 9'(row_data), x.exp); end
        1: check_eq(x.tag, fkeys, x.exp);
        2: check_eq(x.tag, 9'(fkeys4), x.exp);
        3: begin check_eq(x.tag, 9'(ev_cnt - ev_base), x.exp); ev_base = ev_cnt; end
        default: check_eq(x.tag, 9'(key_event), x.exp);
      endcase
    end
    addr_hi = 8'hFF;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    kbd_key = b;
    kbd_key_valid = 1'b1;
    @(negedge clk);
    kbd_key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_hold(input logic [7:0] b, input int cycles);
    @(negedge clk);
    kbd_key = b;
    kbd_key_valid = 1'b1;
    repeat (cycles) @(negedge clk);
    kbd_key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ev_base = ev_cnt;
  endtask

  initial begin
    reset = 1'b1; kbd_key = 8'h00; kbd_key_valid = 1'b0; addr_hi = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    push_row("rst_rows", 8'h00, 5'b11111);
    push("rst_fkeys", 1, 8'hFF, 9'd0);
    push("rst_kev", 4, 8'hFF, 9'd0);
    push_ev("rst_evcnt", 0);
    drain();

    // A make then break
    push_row("a_make", 8'hFD, 5'b11110);
    push_ev("a_make_ev", 1);
    send(8'h1C);
    drain();
    push_row("a_break", 8'hFD, 5'b11111);
    push_ev("a_break_ev", 1);
    send(8'hF0); send(8'h1C);
    drain();

    // Shift+Z, multi-row select with A held
    push_row("shz_fe", 8'hFE, 5'b11100);
    push_row("multi_7c", 8'h7C, 5'b11100);
    push_ev("shz_ev", 3);
    send(8'h12); send(8'h1A); send(8'h1C);
    drain();
    push_row("shz_rel", 8'h00, 5'b11111);
    push_ev("shz_rel_ev", 3);
    send(8'hF0); send(8'h12); send(8'hF0); send(8'h1A); send(8'hF0); send(8'h1C);
    drain();

    // Cursor up = CS+7, shift release interplay
    push_row("up_fe", 8'hFE, 5'b11110);
    push_row("up_ef", 8'hEF, 5'b10111);
    push_ev("up_ev", 1);
    send(8'hE0); send(8'h75);
    drain();
    send(8'h12);
    push_row("up_rel_fe", 8'hFE, 5'b11110);
    push_row("up_rel_ef", 8'hEF, 5'b11111);
    push_ev("up_rel_ev", 2);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    push_row("sh_rel_fe", 8'hFE, 5'b11111);
    push_ev("sh_rel_ev", 1);
    send(8'hF0); send(8'h12);
    drain();

    // Cursor left held while physical shift released keeps CAPS SHIFT
    send(8'hE0); send(8'h6B); send(8'h12); send(8'hF0); send(8'h12);
    push_row("left_fe", 8'hFE, 5'b11110);
    push_row("left_f7", 8'hF7, 5'b01111);
    push_ev("left_ev", 3);
    drain();
    send(8'hE0); send(8'hF0); send(8'h6B);
    push_row("left_rel", 8'h00, 5'b11111);
    drain();
    ev_base = ev_cnt;

    // Extended shift / enter ignored
    push_row("e0_12", 8'h00, 5'b11111);
    push_ev("e0_ev", 0);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h5A);
    drain();

    // Backspace = CS+0
    push_row("bs_fe", 8'hFE, 5'b11110);
    push_row("bs_ef", 8'hEF, 5'b11110);
    push_ev("bs_ev", 1);
    send(8'h66);
    drain();
    send(8'hF0); send(8'h66);
    push_row("bs_rel", 8'h00, 5'b11111);
    drain();
    ev_base = ev_cnt;

    // Pause sequence skipped entirely
    push_row("pause_rows", 8'h00, 5'b11111);
    push("pause_fk", 1, 8'hFF, 9'd0);
    push_ev("pause_ev", 0);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    drain();
    push_row("after_pause", 8'hFB, 5'b11110);
    push_ev("after_pause_ev", 1);
    send(8'h15);
    drain();
    send(8'hF0); send(8'h15);
    ev_base = ev_cnt;

    // Function keys on both widths
    push("fk9", 1, 8'hFF, 9'b1_0000_0001);
    push("fk4", 2, 8'hFF, 9'b0_0000_0001);
    push_ev("fk_ev", 2);
    send(8'h07); send(8'h03);
    drain();
    push("fk9_rel", 1, 8'hFF, 9'd0);
    push("fk4_rel", 2, 8'hFF, 9'd0);
    send(8'hF0); send(8'h07); send(8'hF0); send(8'h03);
    drain();
    push("fk4_drop", 2, 8'hFF, 9'd0);
    push("fk9_f5", 1, 8'hFF, 9'b1_0000_0000);
    send(8'h03);
    drain();
    send(8'hF0); send(8'h03);
    ev_base = ev_cnt;

    // Held level produces one byte only
    push_row("hold_rows", 8'hFD, 5'b11110);
    push_ev("hold_ev", 1);
    send_hold(8'h1C, 4);
    drain();
    send(8'hF0); send(8'h1C);
    ev_base = ev_cnt;

    // Reset after F0, then fresh make and typematic repeat
    send(8'hF0);
    do_reset();
    push_row("rst_f0_r", 8'hFB, 5'b10111);
    push_ev("rst_f0_ev", 1);
    send(8'h2D);
    drain();
    push_row("rep_r", 8'hFB, 5'b10111);
    push_ev("rep_ev", 1);
    send(8'h2D);
    drain();

    // Reset inside SKIP
    send(8'hE1); send(8'h14);
    do_reset();
    push_row("rst_skip_a", 8'hFD, 5'b11110);
    push_row("rst_skip_r", 8'hFB, 5'b11111);
    push_ev("rst_skip_ev", 1);
    send(8'h1C);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
